opfetch: RTL and testbench

Operand-fetch stage sitting directly in front of the single-port GPR file (write-or-read per cycle, 1-cycle registered read, read suppressed on write cycles). Accepts an `rs1`/`rs2` pair from decode and reads both operands serially through the one port. Arbitrates that port against writeback, giving writeback priority. Returns both 32-bit operands with a valid/ready handshake. Operands are coherent with every writeback accepted before the response is presented.

---
 rtl/opfetch_if.sv | 33 +++
 rtl/opfetch.sv | 119 +++++++++++
 tb/tb_opfetch.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/opfetch_if.sv
// Operand-fetch bundle: decode request, operand response, writeback and the
// single-port GPR file connection, seen from the fetch block (slave) or its environment (master).
interface opfetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_src1;
    logic [31:0] rsp_src2;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready, wb_valid, wb_rd, wb_data, rf_rdata,
        output req_ready, rsp_valid, rsp_src1, rsp_src2, wb_ready, rf_wen, rf_waddr,
               rf_wdata, rf_raddr
    );

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready, wb_valid, wb_rd, wb_data, rf_rdata,
        input  req_ready, rsp_valid, rsp_src1, rsp_src2, wb_ready, rf_wen, rf_waddr,
               rf_wdata, rf_raddr
    );
endinterface

// File: rtl/opfetch.sv
// Operand fetch in front of a single-port GPR file: reads rs1 then rs2 through the
// shared port, yields the port to writeback, and snoops writes so operands stay coherent.
module opfetch (
    input  logic     clk,
    input  logic     rst_n,
    opfetch_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {IDLE, RD1, RD2, LAST, RSP} state_t;

    state_t              state;
    logic                req_rdy_q;
    logic                rsp_vld_q;
    logic [4:0]          rs1_q;
    logic [4:0]          rs2_q;
    logic [4:0]          raddr_q;
    logic                cap1;
    logic                cap2;
    logic [DATA_W-1:0]   src1_q;
    logic [DATA_W-1:0]   src2_q;
    logic                snoop_en;
    logic                hit1;
    logic                hit2;

    assign bus.wb_ready  = 1'b1;
    assign bus.rf_wen    = bus.wb_valid && (bus.wb_rd != 5'd0);
    assign bus.rf_waddr  = bus.wb_rd;
    assign bus.rf_wdata  = bus.wb_data;
    assign bus.rf_raddr  = raddr_q;
    assign bus.req_ready = req_rdy_q;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_src1  = src1_q;
    assign bus.rsp_src2  = src2_q;

    // Operands are frozen once presented, so writes only patch latches before RSP.
    assign snoop_en = (state == RD1) || (state == RD2) || (state == LAST);
    assign hit1     = snoop_en && bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1_q);
    assign hit2     = snoop_en && bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_rdy_q <= 1'b1;
            rsp_vld_q <= 1'b0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            raddr_q   <= 5'd0;
            cap1      <= 1'b0;
            cap2      <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
        end else begin
            cap1 <= 1'b0;
            cap2 <= 1'b0;
            // rf_rdata holds across write cycles, so a capture may land in any state.
            if (cap1) src1_q <= bus.rf_rdata;
            if (cap2) src2_q <= bus.rf_rdata;
            if (hit1) src1_q <= bus.wb_data;
            if (hit2) src2_q <= bus.wb_data;

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rs1_q     <= bus.req_rs1;
                        rs2_q     <= bus.req_rs2;
                        req_rdy_q <= 1'b0;
                        if (bus.req_rs1 == 5'd0) src1_q <= '0;
                        if (bus.req_rs2 == 5'd0) src2_q <= '0;
                        if (bus.req_rs1 != 5'd0) begin
                            raddr_q <= bus.req_rs1;
                            state   <= RD1;
                        end else if (bus.req_rs2 != 5'd0) begin
                            raddr_q <= bus.req_rs2;
                            state   <= RD2;
                        end else begin
                            raddr_q   <= bus.req_rs1;
                            state     <= RSP;
                            rsp_vld_q <= 1'b1;
                        end
                    end
                end
                RD1: begin
                    if (!bus.wb_valid) begin
                        cap1 <= 1'b1;
                        if (rs2_q != 5'd0) begin
                            raddr_q <= rs2_q;
                            state   <= RD2;
                        end else begin
                            state <= LAST;
                        end
                    end
                end
                RD2: begin
                    if (!bus.wb_valid) begin
                        cap2  <= 1'b1;
                        state <= LAST;
                    end
                end
                LAST: begin
                    state     <= RSP;
                    rsp_vld_q <= 1'b1;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state     <= IDLE;
                        rsp_vld_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_vld_q <= 1'b0;
                    req_rdy_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_opfetch.sv
// Bench for opfetch: GPR file model on the port side, architectural register model
// checked against every response, plus directed latency/value cases.
module tb_opfetch;
    logic clk;
    logic rst_n;
    opfetch_if bus ();

    opfetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port register file: write-or-read per cycle, registered read.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (bus.rf_wen) mem[bus.rf_waddr] <= bus.rf_wdata;
        else            bus.rf_rdata <= mem[bus.rf_raddr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int wen_cnt = 0;

    logic [31:0] arch [32];
    logic [9:0]  req_q [$];
    bit          in_rsp = 0;
    logic [31:0] held1 = '0;
    logic [31:0] held2 = '0;

    bit          sch_v  [40];
    logic [4:0]  sch_rd [40];
    logic [31:0] sch_d  [40];
    logic [4:0]  raddr_log [40];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: operands equal the architectural registers after every write
    // accepted before the response first appears, then stay frozen until taken.
    initial begin
        logic [9:0] r;
        for (int i = 0; i < 32; i++) arch[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_q.delete();
                in_rsp = 0;
                check("reset rsp_valid", bus.rsp_valid, 0);
                check("reset req_ready", bus.req_ready, 1);
                check("reset rsp_src1", bus.rsp_src1, 0);
                check("reset rsp_src2", bus.rsp_src2, 0);
                check("reset rf_raddr", bus.rf_raddr, 0);
            end else begin
                check("wb_ready", bus.wb_ready, 1);
                check("rf_wen", bus.rf_wen, bus.wb_valid && (bus.wb_rd != 5'd0));
                if (bus.rf_wen) wen_cnt++;
                if (bus.wb_valid) begin
                    check("rf_waddr", bus.rf_waddr, bus.wb_rd);
                    check("rf_wdata", bus.rf_wdata, bus.wb_data);
                end
                check("req_ready&rsp_valid", bus.req_ready && bus.rsp_valid, 0);
                if (bus.rsp_valid) begin
                    if (!in_rsp) begin
                        check("pending request at rsp", req_q.size() != 0, 1);
                        if (req_q.size() != 0) begin
                            r = req_q.pop_front();
                            held1 = arch[r[9:5]];
                            held2 = arch[r[4:0]];
                        end
                        in_rsp = 1;
                    end
                    check("rsp_src1", bus.rsp_src1, held1);
                    check("rsp_src2", bus.rsp_src2, held2);
                    if (bus.rsp_ready) in_rsp = 0;
                end else begin
                    check("rsp_valid dropped early", in_rsp, 0);
                end
                if (bus.req_valid && bus.req_ready) req_q.push_back({bus.req_rs1, bus.req_rs2});
                if (bus.wb_valid && bus.wb_rd != 5'd0) arch[bus.wb_rd] = bus.wb_data;
            end
        end
    end

    task automatic clear_sched();
        for (int i = 0; i < 40; i++) begin
            sch_v[i] = 1'b0; sch_rd[i] = 5'd0; sch_d[i] = '0;
        end
    endtask

    task automatic sched(input int c, input logic [4:0] rd, input logic [31:0] d);
        sch_v[c] = 1'b1; sch_rd[c] = rd; sch_d[c] = d;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
        bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    // Cycle 0 is the accept cycle; lat is the cycle rsp_valid first appears,
    // s1/s2 are the operands seen in the cycle the response is taken.
    task automatic run_req(input logic [4:0] a, input logic [4:0] b, input int hold,
                           output int lat, output logic [31:0] s1, output logic [31:0] s2);
        bit seen;
        bit done;
        int held;
        seen = 0; done = 0; held = 0;
        lat = -1; s1 = '0; s2 = '0; wen_cnt = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (!seen && bus.rsp_valid) begin seen = 1; lat = c; end
            bus.req_valid = (c == 0);
            bus.req_rs1   = a;
            bus.req_rs2   = b;
            bus.wb_valid  = sch_v[c];
            bus.wb_rd     = sch_rd[c];
            bus.wb_data   = sch_d[c];
            bus.rsp_ready = seen && (held >= hold);
            if (bus.rsp_ready) begin
                s1 = bus.rsp_src1; s2 = bus.rsp_src2; done = 1;
            end
            if (seen) held++;
            raddr_log[c] = bus.rf_raddr;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0; bus.wb_valid = 1'b0; bus.rsp_ready = 1'b0;
        check("response taken within budget", done, 1);
        clear_sched();
    endtask

    initial begin
        int lat;
        logic [31:0] s1, s2;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.rsp_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post-reset req_ready", bus.req_ready, 1);
        check("post-reset rsp_valid", bus.rsp_valid, 0);
        check("post-reset rf_wen", bus.rf_wen, 0);

        wb_write(5'd5, 32'h11);
        wb_write(5'd6, 32'h22);
        wb_write(5'd7, 32'h33);

        run_req(5'd5, 5'd6, 0, lat, s1, s2);
        check("basic latency", lat, 4);
        check("basic src1", s1, 32'h11);
        check("basic src2", s2, 32'h22);
        check("basic raddr rs1", raddr_log[1], 5);
        check("basic raddr rs2", raddr_log[2], 6);

        run_req(5'd0, 5'd0, 0, lat, s1, s2);
        check("x0 pair latency", lat, 1);
        check("x0 pair src1", s1, 0);
        check("x0 pair src2", s2, 0);
        check("x0 pair no rf_wen", wen_cnt, 0);

        sched(1, 5'd5, 32'hAA);
        run_req(5'd5, 5'd6, 0, lat, s1, s2);
        check("RD1 stall latency", lat, 5);
        check("RD1 stall src1", s1, 32'hAA);
        check("RD1 stall src2", s2, 32'h22);

        sched(2, 5'd6, 32'h99);
        sched(4, 5'd6, 32'h99);
        run_req(5'd5, 5'd6, 0, lat, s1, s2);
        check("RD2 write latency", lat, 5);
        check("RD2 write src1", s1, 32'hAA);
        check("RD2 write src2", s2, 32'h99);

        sched(3, 5'd6, 32'h5A);
        run_req(5'd5, 5'd6, 0, lat, s1, s2);
        check("LAST snoop latency", lat, 4);
        check("LAST snoop src1", s1, 32'hAA);
        check("LAST snoop src2", s2, 32'h5A);

        sched(1, 5'd0, 32'hFFFF);
        run_req(5'd5, 5'd0, 0, lat, s1, s2);
        check("x0 write no rf_wen", wen_cnt, 0);
        check("x0 write latency", lat, 4);
        check("x0 write src1", s1, 32'hAA);
        check("x0 read src2", s2, 0);

        wb_write(5'd5, 32'h11);
        sched(5, 5'd5, 32'h77);
        sched(6, 5'd5, 32'h77);
        run_req(5'd5, 5'd6, 5, lat, s1, s2);
        check("held rsp latency", lat, 4);
        check("held rsp src1", s1, 32'h11);
        check("held rsp src2", s2, 32'h5A);
        run_req(5'd5, 5'd0, 0, lat, s1, s2);
        check("after hold latency", lat, 3);
        check("after hold src1", s1, 32'h77);

        sched(3, 5'd6, 32'hC3);
        run_req(5'd6, 5'd6, 0, lat, s1, s2);
        check("same index src1", s1, 32'hC3);
        check("same index src2", s2, 32'hC3);

        bus.req_valid = 1'b1; bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd6;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("RD2 raddr before reset", bus.rf_raddr, 6);
        #2 rst_n = 1'b0;
        #1;
        check("async reset rsp_valid", bus.rsp_valid, 0);
        check("async reset req_ready", bus.req_ready, 1);
        check("async reset raddr", bus.rf_raddr, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_req(5'd7, 5'd5, 0, lat, s1, s2);
        check("post-reset req latency", lat, 4);
        check("post-reset req src1", s1, 32'h33);
        check("post-reset req src2", s2, 32'h77);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
